// File: rtl/token_pm_divider_unit_param.sv
// token_pm_divider_unit_param
// Accepts a token-exchange request, divides dividend by divisor with an
// iterative restoring divider (one quotient bit per cycle, MSB first),
// applies the signed, saturated quotient to the local token count and emits
// a token packet that is held until the NoC accepts it.
//
// Ports:
//   clock, rst                  clock, synchronous active-high reset
//   req_valid / req_ready       request handshake
//   dividend, divisor, sign     division operands, 1 = tokens gained
//   zerozero                    delta used when dividend == divisor == 0
//   pkt_addr_in, token_counter  destination address, current token count
//   tokens_next, token_update   updated count, one-cycle commit pulse
//   token_delta                 registered applied delta
//   packet_out*                 packet valid/ready, address, payload
//   busy                        high while a request is in flight
//
// state | meaning
// IDLE  | ready for a request
// DIV   | iterating the restoring divider
// RESP  | packet presented, waiting for packet_out_ready
module token_pm_divider_unit_param #(
  parameter int DIVIDEND_W = 13,
  parameter int DIVISOR_W  = 7,
  parameter int QUOT_W     = 6,
  parameter int TOKEN_W    = 7,
  parameter int ADDR_W     = 5,
  parameter int PKT_W      = 32
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic                  sign,
  input  logic [TOKEN_W-1:0]    zerozero,
  input  logic [ADDR_W-1:0]     pkt_addr_in,
  input  logic [TOKEN_W-1:0]    token_counter,
  output logic [TOKEN_W-1:0]    tokens_next,
  output logic [TOKEN_W-1:0]    token_delta,
  output logic                  token_update,
  output logic                  packet_out,
  input  logic                  packet_out_ready,
  output logic [ADDR_W-1:0]     packet_out_addr,
  output logic [PKT_W-1:0]      packet_out_val,
  output logic                  busy
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  // Partial remainder (DIVISOR_W+1 bits) sits above the dividend; quotient
  // bits are shifted into the freed low end as the dividend shifts out.
  localparam int RD_W  = DIVISOR_W + 1 + DIVIDEND_W;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_nxt;

  logic [RD_W-1:0]       rd_r, rd_sh, rd_nxt;
  logic [DIVISOR_W:0]    part, part_sub;
  logic                  q_bit;
  logic [DIVISOR_W-1:0]  dsr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  sign_r, first_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [TOKEN_W-1:0]    base_r, delta_r, sum_r;

  logic                  accept, zero_path, div_done, load_result, sign_sel;
  logic [DIVIDEND_W-1:0] quo_full;
  logic [QUOT_W-1:0]     q_sat, q_sel;
  logic [TOKEN_W-1:0]    q_ext, delta_nxt, base_sel, sum_sat, neg_delta;
  logic [TOKEN_W:0]      sum_wide;

  // One restoring-division step
  always_comb begin
    rd_sh    = rd_r << 1;
    part     = rd_sh[RD_W-1:DIVIDEND_W];
    q_bit    = (part >= {1'b0, dsr_r});
    part_sub = part - {1'b0, dsr_r};
    rd_nxt   = {(q_bit ? part_sub : part),
                rd_sh[DIVIDEND_W-1:0] | DIVIDEND_W'(q_bit)};
    quo_full = rd_nxt[DIVIDEND_W-1:0];
    q_sat    = (|(quo_full >> QUOT_W)) ? '1 : quo_full[QUOT_W-1:0];
  end

  // Result path: in IDLE it serves the zero-divisor shortcuts straight from
  // the inputs, in DIV it serves the final divide step from captured values.
  always_comb begin
    accept      = req_valid && req_ready;
    zero_path   = (divisor == '0);
    div_done    = (state == DIV) && (cnt_r == '0);
    load_result = (accept && zero_path) || div_done;
    q_sel       = (state == IDLE) ? '1 : q_sat;
    q_ext       = TOKEN_W'(q_sel);
    sign_sel    = (state == IDLE) ? sign : sign_r;
    if ((state == IDLE) && (dividend == '0) && (divisor == '0))
      delta_nxt = zerozero;
    else
      delta_nxt = sign_sel ? q_ext : -q_ext;
    base_sel = (state == IDLE) ? token_counter : base_r;
    sum_wide = {base_sel[TOKEN_W-1], base_sel} + {delta_nxt[TOKEN_W-1], delta_nxt};
    if (sum_wide[TOKEN_W] != sum_wide[TOKEN_W-1])
      sum_sat = sum_wide[TOKEN_W] ? {1'b1, {(TOKEN_W-1){1'b0}}}
                                  : {1'b0, {(TOKEN_W-1){1'b1}}};
    else
      sum_sat = sum_wide[TOKEN_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    busy         = 1'b0;
    packet_out   = 1'b0;
    token_update = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = zero_path ? RESP : DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (cnt_r == '0) state_nxt = RESP;
      end
      RESP: begin
        busy         = 1'b1;
        packet_out   = 1'b1;
        token_update = first_r;
        if (packet_out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_r    <= '0;
      dsr_r   <= '0;
      cnt_r   <= '0;
      sign_r  <= 1'b0;
      first_r <= 1'b0;
      addr_r  <= '0;
      base_r  <= '0;
      delta_r <= '0;
      sum_r   <= '0;
    end else begin
      first_r <= load_result;
      if (accept) begin
        rd_r   <= RD_W'(dividend);
        dsr_r  <= divisor;
        sign_r <= sign;
        addr_r <= pkt_addr_in;
        base_r <= token_counter;
        cnt_r  <= CNT_W'(DIVIDEND_W - 1);
      end else if (state == DIV) begin
        rd_r  <= rd_nxt;
        cnt_r <= cnt_r - CNT_W'(1);
      end
      if (load_result) begin
        delta_r <= delta_nxt;
        sum_r   <= sum_sat;
      end
    end
  end

  // Payload carries the delta as seen by the receiving node (negated).
  assign neg_delta       = -delta_r;
  assign packet_out_val  = PKT_W'(neg_delta);
  assign packet_out_addr = addr_r;
  assign token_delta     = delta_r;
  assign tokens_next     = token_update ? sum_r : token_counter;

endmodule

// File: tb/tb_token_pm_divider_unit_param.sv
// Self-checking bench for token_pm_divider_unit_param: an arithmetic model
// predicts every output each cycle, and directed requests pin the model with
// hand-computed latency, delta, count and payload values.
module tb_token_pm_divider_unit_param;
  localparam int DW = 13, SW = 7, QW = 6, TW = 7, AW = 5, PW = 32;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] dividend = '0;
  logic [SW-1:0] divisor = '0;
  logic          sign = 1'b0;
  logic [TW-1:0] zerozero = '0;
  logic [AW-1:0] pkt_addr_in = '0;
  logic [TW-1:0] token_counter = '0;
  logic [TW-1:0] tokens_next, token_delta;
  logic          token_update, packet_out, busy;
  logic          packet_out_ready = 1'b0;
  logic [AW-1:0] packet_out_addr;
  logic [PW-1:0] packet_out_val;

  always #5 clock = ~clock;

  token_pm_divider_unit_param #(
    .DIVIDEND_W(DW), .DIVISOR_W(SW), .QUOT_W(QW),
    .TOKEN_W(TW), .ADDR_W(AW), .PKT_W(PW)
  ) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .dividend(dividend), .divisor(divisor), .sign(sign), .zerozero(zerozero),
    .pkt_addr_in(pkt_addr_in), .token_counter(token_counter),
    .tokens_next(tokens_next), .token_delta(token_delta),
    .token_update(token_update), .packet_out(packet_out),
    .packet_out_ready(packet_out_ready), .packet_out_addr(packet_out_addr),
    .packet_out_val(packet_out_val), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // m_wait: -1 idle, >0 edges until the response, 0 responding
  int            m_wait = -1;
  bit            m_first = 1'b0;
  bit            m_after_rst = 1'b1;
  int            m_delta = 0;
  int            m_sum = 0;
  logic [AW-1:0] m_addr = '0;

  function automatic int model_delta(int dvd, int dsr, bit sg, int zz);
    int q;
    if (dvd == 0 && dsr == 0) return zz;
    q = (dsr == 0) ? (1 << QW) - 1 : dvd / dsr;
    if (q > (1 << QW) - 1) q = (1 << QW) - 1;
    return sg ? q : -q;
  endfunction

  function automatic int sat(int s);
    if (s > (1 << (TW - 1)) - 1) return (1 << (TW - 1)) - 1;
    if (s < -(1 << (TW - 1))) return -(1 << (TW - 1));
    return s;
  endfunction

  always @(posedge clock) begin
    if (rst) begin
      m_wait = -1; m_first = 1'b0; m_after_rst = 1'b1;
      m_delta = 0; m_sum = 0; m_addr = '0;
    end else if (m_wait == 0) begin
      m_first = 1'b0;
      if (packet_out_ready) m_wait = -1;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_first = 1'b1;
    end else if (req_valid) begin
      m_after_rst = 1'b0;
      m_delta = model_delta(int'(dividend), int'(divisor), sign, int'($signed(zerozero)));
      m_sum   = sat(int'($signed(token_counter)) + m_delta);
      m_addr  = pkt_addr_in;
      if (divisor == '0) begin
        m_wait = 0; m_first = 1'b1;
      end else begin
        m_wait = DW;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [TW-1:0] e_next, e_delta, e_neg;
    @(posedge clock);
    forever begin
      @(negedge clock);
      e_next  = m_first ? TW'(m_sum) : token_counter;
      e_delta = TW'(m_delta);
      e_neg   = TW'(-m_delta);
      chk("req_ready", req_ready, m_wait == -1);
      chk("busy", busy, m_wait != -1);
      chk("packet_out", packet_out, m_wait == 0);
      chk("token_update", token_update, m_first);
      chk("tokens_next", tokens_next, e_next);
      if (m_wait == 0 || m_after_rst) begin
        chk("packet_out_addr", packet_out_addr, m_addr);
        chk("token_delta", token_delta, e_delta);
        chk("packet_out_val", packet_out_val, e_neg);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_req(input string name, input int dvd, input int dsr, input bit sg,
                         input logic [TW-1:0] zz, input logic [TW-1:0] cnt,
                         input logic [AW-1:0] addr, input int hold, input int exp_lat,
                         input logic [TW-1:0] exp_delta, input logic [TW-1:0] exp_next,
                         input logic [PW-1:0] exp_val);
    int lat;
    bit found;
    @(negedge clock); #1;
    dividend = DW'(dvd); divisor = SW'(dsr); sign = sg; zerozero = zz;
    token_counter = cnt; pkt_addr_in = addr;
    req_valid = 1'b1; packet_out_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      lat++;
      if (packet_out) found = 1'b1;
    end
    chk({name, "_latency"}, lat, found ? exp_lat : -1);
    chk({name, "_delta"}, token_delta, exp_delta);
    chk({name, "_tokens_next"}, tokens_next, exp_next);
    chk({name, "_val"}, packet_out_val, exp_val);
    repeat (hold) @(negedge clock);
    #1 packet_out_ready = 1'b1;
    @(negedge clock);
    chk({name, "_ready_after"}, req_ready, 1'b1);
    #1 packet_out_ready = 1'b0;
  endtask

  initial begin
    int seen_pkt, seen_upd;
    repeat (3) @(negedge clock);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_packet_out", packet_out, 1'b0);
    chk("reset_val", packet_out_val, 32'h0);
    #1 rst = 1'b0;

    run_req("div_give",   100, 7, 1'b0, 7'h00, 7'd20, 5'd5,  0, 14, 7'h72, 7'h06, 32'h0000000E);
    run_req("div_satpos", 100, 7, 1'b1, 7'h00, 7'd50, 5'd9,  0, 14, 7'h0E, 7'h3F, 32'h00000072);
    run_req("zerozero",     0, 0, 1'b0, 7'h7B, 7'd10, 5'd17, 0,  1, 7'h7B, 7'h05, 32'h00000005);
    run_req("q_overflow", 8191, 1, 1'b0, 7'h00, 7'd0, 5'd31, 0, 14, 7'h41, 7'h41, 32'h0000003F);
    run_req("div_by_zero",  5, 0, 1'b0, 7'h00, 7'd0,  5'd2,  0,  1, 7'h41, 7'h41, 32'h0000003F);
    run_req("backpress",  100, 7, 1'b0, 7'h00, 7'h44, 5'd12, 5, 14, 7'h72, 7'h40, 32'h0000000E);
    run_req("dz_satpos",    5, 0, 1'b1, 7'h00, 7'd3,  5'd7,  2,  1, 7'h3F, 7'h3F, 32'h00000041);
    run_req("div_gain",    45, 6, 1'b1, 7'h00, 7'h76, 5'd20, 0, 14, 7'h07, 7'h7D, 32'h00000079);

    // Reset in the middle of a divide
    @(negedge clock); #1;
    dividend = 13'd100; divisor = 7'd7; sign = 1'b0; token_counter = 7'd20;
    pkt_addr_in = 5'd3; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clock);
    #1 rst = 1'b1;
    @(negedge clock);
    chk("abort_req_ready", req_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_delta", token_delta, 7'h00);
    chk("abort_addr", packet_out_addr, 5'd0);
    #1 rst = 1'b0;
    seen_pkt = 0; seen_upd = 0;
    repeat (30) begin
      @(negedge clock);
      if (packet_out) seen_pkt++;
      if (token_update) seen_upd++;
    end
    chk("abort_no_packet", seen_pkt, 0);
    chk("abort_no_update", seen_upd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
